// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// Grants are held for at most MAX_BURST accepted words, with zero-bubble handoff.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DWIDTH    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DWIDTH-1:0]   req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          grant_o,
  output logic [DWIDTH-1:0]         fifo_data_o,
  output logic                      fifo_wrreq_o,
  input  logic                      fifo_full_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e            state_r;
  logic [N_REQ-1:0]  grant_r;
  logic [IW-1:0]     last_r;
  logic [CW-1:0]     burst_cnt_r;

  logic              win_found_s;
  logic [IW-1:0]     win_idx_s;
  logic [N_REQ-1:0]  win_onehot_s;
  logic              xfer_s;
  logic              owner_valid_s;
  logic              release_s;

  // First valid requester scanning upward from last+1; last itself is tried last.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] valid,
                                          input logic [IW-1:0]    last);
    logic [IW:0]   pick;
    logic [IW-1:0] idx;
    pick = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (valid[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  assign grant_o = grant_r;

  // Handshake, write strobe, data mux and next-winner selection.
  always_comb begin
    req_ready_o   = grant_r & {N_REQ{~fifo_full_i}};
    xfer_s        = |(req_valid_i & req_ready_o);
    fifo_wrreq_o  = xfer_s;
    owner_valid_s = |(req_valid_i & grant_r);
    release_s     = ~owner_valid_s | (xfer_s & (burst_cnt_r == LAST_BEAT));
    {win_found_s, win_idx_s} = rr_pick(req_valid_i, last_r);
    win_onehot_s  = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
    fifo_data_o   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      fifo_data_o = fifo_data_o | (req_data_i[i*DWIDTH +: DWIDTH] & {DWIDTH{grant_r[i]}});
    end
  end

  // Grant state machine; in GRANT the owner index always equals last_r.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_r     <= ST_IDLE;
      grant_r     <= '0;
      last_r      <= LAST_INIT;
      burst_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            state_r     <= ST_GRANT;
            grant_r     <= win_onehot_s;
            last_r      <= win_idx_s;
            burst_cnt_r <= '0;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            if (win_found_s) begin
              grant_r     <= win_onehot_s;
              last_r      <= win_idx_s;
              burst_cnt_r <= '0;
            end else begin
              state_r     <= ST_IDLE;
              grant_r     <= '0;
              burst_cnt_r <= '0;
            end
          end else if (xfer_s) begin
            burst_cnt_r <= burst_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          grant_r     <= '0;
          last_r      <= LAST_INIT;
          burst_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle vector table, queued
// expected FIFO words for directed sequences, and a randomized regression.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              srst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      grant;
  logic [DW-1:0]     fifo_data;
  logic              fifo_wrreq;
  logic              fifo_full;

  int checks   = 0;
  int failures = 0;

  int          cnt   [N];
  int          lim   [N];
  int          start [N];
  logic [15:0] base  [N];
  int          cyc;
  logic [15:0] exp_q [$];

  typedef struct packed {
    logic [3:0]  valid;
    logic        full;
    logic [3:0]  grant;
    logic [3:0]  ready;
    logic        wr;
    logic [15:0] data;
  } vec_t;
  vec_t vecs [$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DWIDTH(DW), .MAX_BURST(8)) dut (
    .clk_i        (clk),
    .srst_i       (srst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .grant_o      (grant),
    .fifo_data_o  (fifo_data),
    .fifo_wrreq_o (fifo_wrreq),
    .fifo_full_i  (fifo_full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    srst      = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i]   = 0;
      lim[i]   = 0;
      start[i] = 0;
      base[i]  = 16'(i << 12);
    end
    cyc = 0;
    exp_q.delete();
  endtask

  task automatic add_vec(input logic [3:0] v, input logic f, input logic [3:0] g,
                         input logic [3:0] r, input logic w, input logic [15:0] d);
    vecs.push_back({v, f, g, r, w, d});
  endtask

  // mode 0: compare writes against exp_q; 1: per-producer order; 2: as 1 with random stimulus
  task automatic run_cycle(input int mode, output logic [N-1:0] g, output logic w);
    int p;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (cyc >= start[i]) && (cnt[i] < lim[i]) &&
                     ((mode != 2) || ($urandom_range(0, 99) < 60));
      req_data[i*DW +: DW] = base[i] + 16'(cnt[i]);
    end
    if (mode == 2) fifo_full = ($urandom_range(0, 99) < 30);
    #1;
    g = grant;
    w = fifo_wrreq;
    check("no_wr_while_full", 32'(fifo_wrreq & fifo_full), 32'd0);
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    if (fifo_wrreq) begin
      if (mode == 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got 0x%0h expected no write", fifo_data);
        end else begin
          check("fifo_word", 32'(fifo_data), 32'(exp_q.pop_front()));
        end
      end else begin
        p = 0;
        for (int i = 0; i < N; i++) if (grant[i]) p = i;
        check("per_producer_order", 32'(fifo_data), 32'(base[p] + 16'(cnt[p])));
      end
    end
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) cnt[i]++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    logic [N-1:0] g;
    logic         w;
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      run_cycle(0, g, w);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] g;
    logic         w;
    vec_t         v;

    // Per-cycle table: reset state, 1-cycle grant latency, full stall mid-burst,
    // zero-bubble handoff, early valid drop, return to idle.
    add_vec(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0000);
    add_vec(4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) add_vec(4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, 16'hD001);
    for (int i = 0; i < 5; i++) add_vec(4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b0, 16'hD001);
    for (int i = 0; i < 4; i++) add_vec(4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, 16'hD001);
    add_vec(4'b1010, 1'b0, 4'b0010, 4'b0010, 1'b1, 16'hD001);
    add_vec(4'b1010, 1'b0, 4'b1000, 4'b1000, 1'b1, 16'hD003);
    add_vec(4'b0001, 1'b0, 4'b1000, 4'b1000, 1'b0, 16'hD003);
    add_vec(4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 16'hD000);
    add_vec(4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b0, 16'hD000);
    add_vec(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0000);

    reset_dut();
    for (int i = 0; i < vecs.size(); i++) begin
      v         = vecs[i];
      req_valid = v.valid;
      fifo_full = v.full;
      req_data  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
      #1;
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(v.grant));
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(v.ready));
      check($sformatf("vec%0d_wrreq", i), 32'(fifo_wrreq), 32'(v.wr));
      check($sformatf("vec%0d_data", i), 32'(fifo_data), 32'(v.data));
      @(negedge clk);
    end

    // Single producer 2 streams 20 words with continuous re-grants.
    reset_dut();
    lim[2]  = 20;
    base[2] = 16'h0100;
    for (int n = 0; n < 20; n++) exp_q.push_back(16'h0100 + 16'(n));
    run_cycle(0, g, w);
    check("single_grant_c0", 32'(g), 32'd0);
    for (int c = 1; c <= 20; c++) begin
      run_cycle(0, g, w);
      check("single_grant_held", 32'(g), 32'b0100);
      check("single_no_bubble", 32'(w), 32'd1);
    end
    check("single_drain", 32'(exp_q.size()), 32'd0);

    // All four producers continuously valid: bursts of 8 in order 0,1,2,3,0,...
    reset_dut();
    for (int i = 0; i < N; i++) lim[i] = 100;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++)
        for (int n = 0; n < 8; n++) exp_q.push_back(16'(p << 12) + 16'(r * 8 + n));
    run_cycle(0, g, w);
    check("rr_grant_c0", 32'(g), 32'd0);
    for (int c = 1; c <= 64; c++) begin
      run_cycle(0, g, w);
      check("rr_wrreq_every_cycle", 32'(w), 32'd1);
    end
    check("rr_drain", 32'(exp_q.size()), 32'd0);

    // Owner 0 drops valid after 2 words; producer 3 then gets a full burst before 1.
    reset_dut();
    lim[0]   = 2;
    lim[3]   = 20;
    lim[1]   = 20;
    start[1] = 4;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    for (int n = 0; n < 8; n++) exp_q.push_back(16'h3000 + 16'(n));
    for (int n = 0; n < 8; n++) exp_q.push_back(16'h1000 + 16'(n));
    drain("early_drop_order", 60);

    // Reset pulsed during owner 2's fourth word.
    reset_dut();
    lim[2]   = 100;
    lim[1]   = 100;
    start[1] = 4;
    for (int c = 0; c < 4; c++) run_cycle(1, g, w);
    check("rst_pre_grant", 32'(g), 32'b0100);
    srst = 1'b1;
    run_cycle(1, g, w);
    check("rst_fourth_word", 32'(w), 32'd1);
    srst = 1'b0;
    run_cycle(1, g, w);
    check("rst_grant_cleared", 32'(g), 32'd0);
    check("rst_wrreq_cleared", 32'(w), 32'd0);
    run_cycle(1, g, w);
    check("rst_first_grant_p1", 32'(g), 32'b0010);

    // Random valids and data with 30% full duty.
    reset_dut();
    for (int i = 0; i < N; i++) lim[i] = 1 << 30;
    for (int c = 0; c < 10000; c++) run_cycle(2, g, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
